// File: rtl/seq_divider_p.sv
// Restoring sequential divider behind a four-phase REQ/ACK handshake.
// One quotient bit per clock, with signed/unsigned mode and a short-cut path for divide-by-zero and MIN/-1.
module seq_divider_p #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             SGN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] D,
  output logic             ACK,
  output logic             BUSY,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             FDBZ,
  output logic             FOVF
);

  // state | meaning
  // IDLE  | waiting for REQ; operands are latched on the accepting edge
  // CALC  | one restoring step per edge, counter runs WIDTH down to 0
  // FIX   | sign correction / exception results written, ACK raised
  // DONE  | ACK held until REQ is seen low
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES  = '1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             fdbz_q, fdbz_d;
  logic             fovf_q, fovf_d;

  logic             a_neg, d_neg;
  logic [WIDTH-1:0] a_mag, d_mag;
  logic             is_dbz, is_ovf;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign a_neg  = SGN & A[WIDTH-1];
  assign d_neg  = SGN & D[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign d_mag  = d_neg ? -D : D;
  assign is_dbz = (D == '0);
  assign is_ovf = SGN && (A == MIN_V) && (D == ONES);

  // The shifted partial remainder needs WIDTH+1 bits; after a successful
  // subtraction the difference is below the divisor, so WIDTH bits suffice.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign fits   = (rem_sh >= {1'b0, dmag_q});
  assign diff   = rem_sh[WIDTH-1:0] - dmag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    araw_d  = araw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    q_d     = q_q;
    r_d     = r_q;
    fdbz_d  = fdbz_q;
    fovf_d  = fovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          busy_d  = 1'b1;
          araw_d  = A;
          qneg_d  = a_neg ^ d_neg;
          rneg_d  = a_neg;
          dbz_d   = is_dbz;
          ovf_d   = is_ovf;
          quo_d   = a_mag;
          dmag_d  = d_mag;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = (is_dbz || is_ovf) ? S_FIX : S_CALC;
        end
      end

      S_CALC: begin
        rem_d = fits ? diff : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (dbz_q) begin
          q_d    = '0;
          r_d    = araw_q;
          fdbz_d = 1'b1;
          fovf_d = 1'b0;
        end else if (ovf_q) begin
          q_d    = MIN_V;
          r_d    = '0;
          fdbz_d = 1'b0;
          fovf_d = 1'b1;
        end else begin
          // Truncating division: remainder follows the dividend's sign.
          q_d    = qneg_q ? -quo_q : quo_q;
          r_d    = rneg_q ? -rem_q : rem_q;
          fdbz_d = 1'b0;
          fovf_d = 1'b0;
        end
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!REQ) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      araw_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      fdbz_q  <= 1'b0;
      fovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      araw_q  <= araw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
      r_q     <= r_d;
      fdbz_q  <= fdbz_d;
      fovf_q  <= fovf_d;
    end
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign FDBZ = fdbz_q;
  assign FOVF = fovf_q;

endmodule

// File: tb/tb_seq_divider_p.sv
// Bench for seq_divider_p: vector table plus model-driven random requests on a 16-bit instance,
// handshake/reset corner sequences, and an 8-bit instance for the narrow overflow case.
module tb_seq_divider_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req16, sgn16, ack16, busy16, fdbz16, fovf16;
  logic [15:0] a16, d16, q16, r16;
  logic        req8, sgn8, ack8, busy8, fdbz8, fovf8;
  logic [7:0]  a8, d8, q8, r8;

  seq_divider_p #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .RST(rst_n), .REQ(req16), .SGN(sgn16), .A(a16), .D(d16),
    .ACK(ack16), .BUSY(busy16), .Q(q16), .R(r16), .FDBZ(fdbz16), .FOVF(fovf16)
  );

  seq_divider_p #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst_n), .REQ(req8), .SGN(sgn8), .A(a8), .D(d8),
    .ACK(ack8), .BUSY(busy8), .Q(q8), .R(r8), .FDBZ(fdbz8), .FOVF(fovf8)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        fdbz;
    logic        fovf;
  } res_t;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] r;
    logic        fdbz;
    logic        fovf;
    int          lat;
    int          hold;
    logic        zap;
  } vec_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input logic inst);
    return inst ? ack8 : ack16;
  endfunction
  function automatic logic get_busy(input logic inst);
    return inst ? busy8 : busy16;
  endfunction
  function automatic logic [63:0] get_q(input logic inst);
    return inst ? {56'b0, q8} : {48'b0, q16};
  endfunction
  function automatic logic [63:0] get_r(input logic inst);
    return inst ? {56'b0, r8} : {48'b0, r16};
  endfunction
  function automatic logic get_fdbz(input logic inst);
    return inst ? fdbz8 : fdbz16;
  endfunction
  function automatic logic get_fovf(input logic inst);
    return inst ? fovf8 : fovf16;
  endfunction

  function automatic res_t model16(input logic sgn, input logic [15:0] a, input logic [15:0] d);
    res_t e;
    logic signed [15:0] sa, sd;
    logic [15:0] qq, rr;
    sa = a;
    sd = d;
    e.fdbz = 1'b0;
    e.fovf = 1'b0;
    if (d == 16'h0) begin
      qq = 16'h0;
      rr = a;
      e.fdbz = 1'b1;
    end else if (sgn && a == 16'h8000 && d == 16'hFFFF) begin
      qq = 16'h8000;
      rr = 16'h0;
      e.fovf = 1'b1;
    end else if (sgn) begin
      qq = sa / sd;
      rr = sa % sd;
    end else begin
      qq = a / d;
      rr = a % d;
    end
    e.q = {48'b0, qq};
    e.r = {48'b0, rr};
    return e;
  endfunction

  task automatic drive(input logic inst, input logic req, input logic sgn,
                       input logic [63:0] a, input logic [63:0] d);
    if (inst) begin
      req8 = req; sgn8 = sgn; a8 = a[7:0]; d8 = d[7:0];
    end else begin
      req16 = req; sgn16 = sgn; a16 = a[15:0]; d16 = d[15:0];
    end
  endtask

  task automatic set_req(input logic inst, input logic v);
    if (inst) req8 = v;
    else      req16 = v;
  endtask

  // Wait (bounded) for ACK after the latch edge; returns edges seen after e0.
  task automatic wait_ack(input logic inst, output int n);
    n = 0;
    while (!get_ack(inst) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic inst, input res_t e);
    chk({tag, ".q"},    get_q(inst),          e.q);
    chk({tag, ".r"},    get_r(inst),          e.r);
    chk({tag, ".fdbz"}, 64'(get_fdbz(inst)),  64'(e.fdbz));
    chk({tag, ".fovf"}, 64'(get_fovf(inst)),  64'(e.fovf));
  endtask

  task automatic run_req(input string tag, input logic inst, input logic sgn,
                         input logic [63:0] a, input logic [63:0] d, input res_t e,
                         input int lat, input int hold, input logic zap);
    int   n;
    res_t got;
    @(negedge clk);
    drive(inst, 1'b1, sgn, a, d);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (zap) drive(inst, 1'b1, 1'b0, 64'h0, 64'h0);
    chk({tag, ".busy_latch"}, 64'(get_busy(inst)), 64'h1);
    wait_ack(inst, n);
    chk({tag, ".latency"}, 64'(n + 1), 64'(lat));
    chk({tag, ".busy_ack"}, 64'(get_busy(inst)), 64'h0);
    got = exp_q.pop_front();
    check_result(tag, inst, got);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".ack_hold"}, 64'(get_ack(inst)), 64'h1);
      chk({tag, ".q_hold"}, get_q(inst), got.q);
      chk({tag, ".r_hold"}, get_r(inst), got.r);
    end
    @(negedge clk);
    set_req(inst, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".ack_fall"}, 64'(get_ack(inst)), 64'h0);
    chk({tag, ".q_after"}, get_q(inst), got.q);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    res_t e;
    int   n;
    logic        rs;
    logic [15:0] ra, rd;

    tbl[0] = '{1'b1, 16'd100,   16'hFFFD, 16'hFFDF, 16'h0001, 1'b0, 1'b0, 18, 0, 1'b0};
    tbl[1] = '{1'b1, 16'hFF9C,  16'd3,    16'hFFDF, 16'hFFFF, 1'b0, 1'b0, 18, 1, 1'b0};
    tbl[2] = '{1'b1, 16'h8000,  16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 18, 2, 1'b0};
    tbl[3] = '{1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 2,  3, 1'b0};
    tbl[4] = '{1'b1, 16'd7,     16'h0000, 16'h0000, 16'h0007, 1'b1, 1'b0, 2,  4, 1'b0};
    tbl[5] = '{1'b0, 16'hFFFF,  16'h0002, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18, 0, 1'b0};
    tbl[6] = '{1'b0, 16'h8000,  16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 18, 1, 1'b0};
    tbl[7] = '{1'b1, 16'd100,   16'hFFFD, 16'hFFDF, 16'h0001, 1'b0, 1'b0, 18, 2, 1'b1};
    tbl[8] = '{1'b1, 16'hFFF9,  16'h0000, 16'h0000, 16'hFFF9, 1'b1, 1'b0, 2,  0, 1'b0};
    tbl[9] = '{1'b0, 16'hFFFF,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 18, 0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset.ack",  64'(get_ack(k[0])),  64'h0);
      chk("reset.busy", 64'(get_busy(k[0])), 64'h0);
      chk("reset.q",    get_q(k[0]),         64'h0);
      chk("reset.r",    get_r(k[0]),         64'h0);
      chk("reset.fdbz", 64'(get_fdbz(k[0])), 64'h0);
      chk("reset.fovf", 64'(get_fovf(k[0])), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.q    = {48'b0, tbl[i].q};
      e.r    = {48'b0, tbl[i].r};
      e.fdbz = tbl[i].fdbz;
      e.fovf = tbl[i].fovf;
      run_req($sformatf("vec%0d", i), 1'b0, tbl[i].sgn, {48'b0, tbl[i].a}, {48'b0, tbl[i].d},
              e, tbl[i].lat, tbl[i].hold, tbl[i].zap);
    end

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      if (i % 3 == 0) rd = 16'($urandom_range(1, 20));
      else            rd = 16'($urandom);
      if (i % 4 == 1) rd = -rd;
      e = model16(rs, ra, rd);
      run_req($sformatf("rnd%0d", i), 1'b0, rs, {48'b0, ra}, {48'b0, rd}, e,
              (e.fdbz || e.fovf) ? 2 : 18, int'($urandom_range(0, 4)), 1'b0);
    end

    // REQ withdrawn mid-calculation: the result still arrives, ACK pulses once.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 64'd1000, 64'd7);
    exp_q.push_back(model16(1'b0, 16'd1000, 16'd7));
    @(posedge clk);
    repeat (3) @(negedge clk);
    req16 = 1'b0;
    #1;
    wait_ack(1'b0, n);
    chk("drop.ack_seen", 64'(ack16), 64'h1);
    e = exp_q.pop_front();
    check_result("drop", 1'b0, e);
    @(posedge clk); #1;
    chk("drop.ack_pulse", 64'(ack16), 64'h0);
    chk("drop.busy", 64'(busy16), 64'h0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 64'd50, 64'd3);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("abort.busy_calc", 64'(busy16), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.ack",  64'(ack16),  64'h0);
    chk("abort.busy", 64'(busy16), 64'h0);
    chk("abort.q",    {48'b0, q16}, 64'h0);
    chk("abort.r",    {48'b0, r16}, 64'h0);
    chk("abort.fdbz", 64'(fdbz16), 64'h0);
    chk("abort.fovf", 64'(fovf16), 64'h0);
    req16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = model16(1'b0, 16'd9, 16'd2);
    run_req("post_abort", 1'b0, 1'b0, 64'd9, 64'd2, e, 18, 0, 1'b0);

    // Narrow instance.
    e.q = 64'h80; e.r = 64'h0; e.fdbz = 1'b0; e.fovf = 1'b1;
    run_req("w8_ovf", 1'b1, 1'b1, 64'h80, 64'hFF, e, 2, 1, 1'b0);
    e.q = 64'hFD; e.r = 64'hFF; e.fdbz = 1'b0; e.fovf = 1'b0;
    run_req("w8_neg", 1'b1, 1'b1, 64'hF9, 64'h02, e, 10, 0, 1'b0);
    e.q = 64'h00; e.r = 64'h2A; e.fdbz = 1'b1; e.fovf = 1'b0;
    run_req("w8_dbz", 1'b1, 1'b0, 64'h2A, 64'h00, e, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_p.md
Name: seq_divider_p

Overview:
Parametrised successor to the team's 16-bit REQ/ACK divider. Multi-cycle restoring divider, one quotient bit per clock. Adds:
- configurable operand width
- a per-request signed/unsigned mode
- an overflow flag
- a short-cut path for exceptional cases

Sits behind the same four-phase REQ/ACK handshake, so existing requesters and benches port over unchanged.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 2..64)

Ports:
CLK   input   1      rising-edge clock
RST   input   1      asynchronous, active-low reset (0 = reset asserted)
REQ   input   1      four-phase request from requester
SGN   input   1      1 = two's-complement operands, 0 = unsigned; sampled with A/D
A     input   WIDTH  dividend
D     input   WIDTH  divisor
ACK   output  1      four-phase acknowledge; results valid while 1
BUSY  output  1      1 from operand latch until ACK rises
Q     output  WIDTH  quotient
R     output  WIDTH  remainder
FDBZ  output  1      divide-by-zero flag for the last completed request
FOVF  output  1      signed overflow flag (MIN / -1) for the last completed request

Behaviour:
- Reset (RST=0, asynchronous):
  - state IDLE; ACK, BUSY, Q, R, FDBZ, FOVF all 0
  - internal registers cleared
  - reset mid-operation aborts immediately; no result is produced
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - At a rising edge with REQ=1 (edge e0), latch A, D and SGN internally and set BUSY=1.
  - Operands may change after e0 without effect.
  - If D==0, or (SGN=1 and A==MIN and D==-1): go to FIX directly.
  - Otherwise: load magnitudes (absolute values if SGN=1), counter=WIDTH, go to CALC.
- CALC:
  - Each edge: shift partial remainder left one bit, trial-subtract divisor magnitude, shift in quotient bit, decrement counter.
  - When the counter reaches 0, go to FIX.
- FIX (one edge), applies sign correction and exceptions, then writes the registered outputs and moves to DONE:
  - Quotient negated if SGN=1 and operand signs differ.
  - Remainder takes the sign of the dividend (truncating division: A = Q*D + R, |R| < |D|).
  - Divide by zero: Q=0, R=A (raw), FDBZ=1, FOVF=0.
  - Overflow: Q=MIN (0x8000 for WIDTH=16), R=0, FOVF=1, FDBZ=0.
  - Normal result: FDBZ=0, FOVF=0.
- Writes to Q/R/FDBZ/FOVF and ACK happen at the same edge as the FIX-to-DONE transition; at that edge ACK=1 and BUSY=0.
- Latency from the latch edge e0 to ACK rising: WIDTH+2 edges normally; 2 edges on the exception path.
- DONE:
  - ACK held at 1; outputs stable.
  - At the first edge with REQ=0: ACK=0, go to IDLE.
- Q/R/FDBZ/FOVF hold their last result until the next FIX edge; they are never cleared except by reset.
- A new request is accepted at the first edge where state=IDLE and REQ=1. The earliest is the edge after ACK falls, provided REQ has been reasserted.
- REQ dropping during CALC/FIX (protocol violation): the computation completes. On reaching DONE with REQ=0, ACK still pulses high for exactly one cycle.
- Unsigned mode: no overflow case exists; FOVF is always 0. 0xFFFF is treated as 65535.
- Internal arithmetic uses a WIDTH+1-bit partial remainder, so the MIN magnitude is representable.

Test Plan:
All cases use WIDTH=16 unless stated.
- SGN=1, A=100, D=-3 -> Q=-33, R=1, FDBZ=0, FOVF=0; ACK rises 18 edges after the latch edge.
- SGN=1, A=-100, D=3 -> Q=-33, R=-1. SGN=1, A=-32768, D=-32768 -> Q=1, R=0.
- SGN=1, A=-32768, D=-1 -> Q=-32768, R=0, FOVF=1; ACK 2 edges after latch. Then SGN=1, A=7, D=0 -> Q=0, R=7, FDBZ=1, FOVF=0.
- SGN=0, A=0xFFFF, D=0x0002 -> Q=0x7FFF, R=0x0001. SGN=0, A=0x8000, D=0xFFFF -> Q=0, R=0x8000, FOVF=0.
- Handshake: zero A/D 1 ns after the latch edge; result is unchanged. Hold REQ high 0..4 extra cycles after ACK; ACK stays 1 until the edge after REQ=0; Q/R stay stable throughout.
- Pull RST low for half a cycle during CALC -> ACK/BUSY/Q/R/flags go 0 without waiting for a clock edge. A subsequent request 9/2 returns Q=4, R=1. Repeat with a WIDTH=8 instance: A=-128, D=-1 gives FOVF=1, Q=0x80.
